// File: rtl/direction_pkg.sv
// direction_pkg: shared axis-state enum, 2-bit direction codes and the
// state-to-code mapping used by direction_encoder and axis_classifier.
package direction_pkg;

   typedef enum logic [1:0] {
      NEUTRAL = 2'd0,
      NEG     = 2'd1,
      POS     = 2'd2
   } axis_state_t;

   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_NEG  = 2'b10;
   localparam logic [1:0] DIR_POS  = 2'b11;

   function automatic logic [1:0] state_to_code(input axis_state_t st);
      case (st)
         NEG:     return DIR_NEG;
         POS:     return DIR_POS;
         default: return DIR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/direction_encoder_axis_classifier.sv
// axis_classifier: per-axis dead-zone classification, confirmation over
// CONFIRM consecutive agreeing samples, and the committed direction code.
// Build option: DIRENC_HYST_EN relaxes the release thresholds by HYST.
module axis_classifier
   import direction_pkg::*;
#(
   parameter int ADC_W   = 12,
   parameter int CENTER  = 2048,
   parameter int DEAD    = 400,
   parameter int HYST    = 64,
   parameter int CONFIRM = 4
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             clear,
   input  logic             sample_valid,
   input  logic [ADC_W-1:0] sample,
   output logic [1:0]       code,
   output logic [1:0]       code_next
);

   localparam logic [ADC_W:0] POS_ENTER = (ADC_W+1)'(CENTER + DEAD);
   localparam logic [ADC_W:0] NEG_ENTER = (ADC_W+1)'(CENTER - DEAD);
`ifdef DIRENC_HYST_EN
   localparam logic [ADC_W:0] POS_HOLD  = (ADC_W+1)'(CENTER + DEAD - HYST);
   localparam logic [ADC_W:0] NEG_HOLD  = (ADC_W+1)'(CENTER - DEAD + HYST);
`else
   localparam logic [ADC_W:0] POS_HOLD  = POS_ENTER;
   localparam logic [ADC_W:0] NEG_HOLD  = NEG_ENTER;
`endif
   localparam logic [3:0]     CONF      = 4'(CONFIRM);

   axis_state_t state_q, state_d;
   axis_state_t cand_q, cand_d;
   axis_state_t cls;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  cnt_inc;
   logic [ADC_W:0] samp;
   logic [ADC_W:0] pos_thr;
   logic [ADC_W:0] neg_thr;

   // Raw class of the current sample; committed state picks the release threshold
   always_comb begin
      samp    = {1'b0, sample};
      pos_thr = (state_q == POS) ? POS_HOLD : POS_ENTER;
      neg_thr = (state_q == NEG) ? NEG_HOLD : NEG_ENTER;
      if (samp >= pos_thr)
         cls = POS;
      else if (samp <= neg_thr)
         cls = NEG;
      else
         cls = NEUTRAL;
   end

   // State register: committed state, candidate class and agreement counter
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= NEUTRAL;
         cand_q  <= NEUTRAL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: confirm a candidate over CONFIRM agreeing samples before committing
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      cnt_inc = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
      if (clear) begin
         state_d = NEUTRAL;
         cand_d  = NEUTRAL;
         cnt_d   = '0;
      end else if (sample_valid) begin
         if (cls == state_q) begin
            cnt_d = '0;
         end else if (cls == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CONF) begin
               state_d = cand_q;
               cnt_d   = '0;
            end
         end else begin
            cand_d = cls;
            cnt_d  = 4'd1;
            if (CONF <= 4'd1) begin
               state_d = cls;
               cnt_d   = '0;
            end
         end
      end
   end

   // Outputs: current and next-cycle direction codes
   always_comb begin
      code      = state_to_code(state_q);
      code_next = state_to_code(state_d);
   end

endmodule

// File: rtl/direction_encoder.sv
// direction_encoder: joystick ADC samples and stop button to registered
// direction codes for the seven-segment display. Stop button is synchronised
// and debounced here; each axis is handled by an axis_classifier.
// Build option: DIRENC_HYST_EN (hysteresis on direction release).
module direction_encoder
   import direction_pkg::*;
#(
   parameter int ADC_W          = 12,
   parameter int CENTER         = 2048,
   parameter int DEAD           = 400,
   parameter int HYST           = 64,
   parameter int CONFIRM        = 4,
   parameter int STOP_DB_CYCLES = 50000
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic [ADC_W-1:0] adc_x,
   input  logic [ADC_W-1:0] adc_y,
   input  logic             adc_valid,
   input  logic             stop_btn_n,
   output logic [1:0]       data_x,
   output logic [1:0]       data_y,
   output logic             data_stop,
   output logic             dir_changed
);

   localparam int               DB_W   = $clog2(STOP_DB_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_MAX = DB_W'(STOP_DB_CYCLES);

   logic            sync1, sync2;
   logic            differ;
   logic [DB_W-1:0] db_cnt;
   logic            stop_next;
   logic            axis_clear;
   logic [1:0]      x_next, y_next;

   // Two-flop synchroniser, idles released (high)
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= stop_btn_n;
         sync2 <= sync1;
      end
   end

   // The synchronised level disagrees with data_stop when its pressed
   // meaning (~sync2) differs; any return to agreement restarts the count.
   always_comb begin
      differ    = (sync2 == data_stop);
      stop_next = data_stop;
      if (differ && db_cnt == DB_MAX)
         stop_next = ~sync2;
      axis_clear = stop_next | data_stop;
   end

   // Debounce counter: counts stable disagreeing cycles
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N)
         db_cnt <= '0;
      else if (differ && db_cnt != DB_MAX)
         db_cnt <= db_cnt + 1'b1;
      else
         db_cnt <= '0;
   end

   // Registered stop flag and change pulse aligned with the updated outputs
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         data_stop   <= 1'b0;
         dir_changed <= 1'b0;
      end else begin
         data_stop   <= stop_next;
         dir_changed <= ({x_next, y_next, stop_next} != {data_x, data_y, data_stop});
      end
   end

   axis_classifier #(
      .ADC_W   (ADC_W),
      .CENTER  (CENTER),
      .DEAD    (DEAD),
      .HYST    (HYST),
      .CONFIRM (CONFIRM)
   ) u_axis_x (
      .iCLK         (iCLK),
      .iRST_N       (iRST_N),
      .clear        (axis_clear),
      .sample_valid (adc_valid),
      .sample       (adc_x),
      .code         (data_x),
      .code_next    (x_next)
   );

   axis_classifier #(
      .ADC_W   (ADC_W),
      .CENTER  (CENTER),
      .DEAD    (DEAD),
      .HYST    (HYST),
      .CONFIRM (CONFIRM)
   ) u_axis_y (
      .iCLK         (iCLK),
      .iRST_N       (iRST_N),
      .clear        (axis_clear),
      .sample_valid (adc_valid),
      .sample       (adc_y),
      .code         (data_y),
      .code_next    (y_next)
   );

endmodule

// File: tb/tb_direction_encoder.sv
// tb_direction_encoder: directed scoreboard bench for direction_encoder
// with STOP_DB_CYCLES=16 (thresholds 2448/1648).
module tb_direction_encoder;

`ifdef DIRENC_HYST_EN
   localparam bit HYST_ON = 1'b1;
`else
   localparam bit HYST_ON = 1'b0;
`endif

   logic        iCLK = 1'b0;
   logic        iRST_N;
   logic [11:0] adc_x, adc_y;
   logic        adc_valid;
   logic        stop_btn_n;
   logic [1:0]  data_x, data_y;
   logic        data_stop, dir_changed;

   typedef struct {
      string      tag;
      logic [1:0] x;
      logic [1:0] y;
      logic       stop;
      logic       chg;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   direction_encoder #(
      .STOP_DB_CYCLES (16)
   ) dut (
      .iCLK        (iCLK),
      .iRST_N      (iRST_N),
      .adc_x       (adc_x),
      .adc_y       (adc_y),
      .adc_valid   (adc_valid),
      .stop_btn_n  (stop_btn_n),
      .data_x      (data_x),
      .data_y      (data_y),
      .data_stop   (data_stop),
      .dir_changed (dir_changed)
   );

   always #5 iCLK = ~iCLK;

   task automatic push_exp(input string tag, input logic [1:0] x, input logic [1:0] y,
                           input logic stop, input logic chg);
      exp_t e;
      e.tag = tag; e.x = x; e.y = y; e.stop = stop; e.chg = chg;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      assert (data_x === e.x) else begin
         n_err++;
         $error("FAIL %s data_x observed=%b expected=%b", e.tag, data_x, e.x);
      end
      n_vec++;
      assert (data_y === e.y) else begin
         n_err++;
         $error("FAIL %s data_y observed=%b expected=%b", e.tag, data_y, e.y);
      end
      n_vec++;
      assert (data_stop === e.stop) else begin
         n_err++;
         $error("FAIL %s data_stop observed=%b expected=%b", e.tag, data_stop, e.stop);
      end
      n_vec++;
      assert (dir_changed === e.chg) else begin
         n_err++;
         $error("FAIL %s dir_changed observed=%b expected=%b", e.tag, dir_changed, e.chg);
      end
   endtask

   // One valid sample; expectation is for the outputs after its clock edge
   task automatic sample(input string tag, input int x, input int y,
                         input logic [1:0] ex, input logic [1:0] ey,
                         input logic es, input logic ec);
      @(negedge iCLK);
      adc_x     = 12'(x);
      adc_y     = 12'(y);
      adc_valid = 1'b1;
      push_exp(tag, ex, ey, es, ec);
      @(negedge iCLK);
      adc_valid = 1'b0;
      check_out();
   endtask

   // Four identical samples: first three leave outputs unchanged
   task automatic run4(input string tag, input int x, input int y,
                       input logic [1:0] ox, input logic [1:0] oy,
                       input logic [1:0] nx, input logic [1:0] ny,
                       input logic es, input logic ec);
      for (int i = 0; i < 3; i++)
         sample(tag, x, y, ox, oy, es, 1'b0);
      sample(tag, x, y, nx, ny, es, ec);
   endtask

   task automatic idle(input string tag, input logic [1:0] ex, input logic [1:0] ey,
                       input logic es, input logic ec);
      push_exp(tag, ex, ey, es, ec);
      @(negedge iCLK);
      check_out();
   endtask

   initial begin
      iRST_N     = 1'b0;
      adc_x      = '0;
      adc_y      = '0;
      adc_valid  = 1'b0;
      stop_btn_n = 1'b1;
      repeat (3) @(negedge iCLK);
      push_exp("reset", 2'b00, 2'b00, 1'b0, 1'b0);
      check_out();
      iRST_N = 1'b1;

      // Commit right, pulse lasts one cycle
      run4("right", 3000, 2048, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1);
      idle("right_pulse_end", 2'b11, 2'b00, 1'b0, 1'b0);

      // Release thresholds
      run4("rel_2400", 2400, 2048, 2'b11, 2'b00,
           HYST_ON ? 2'b11 : 2'b00, 2'b00, 1'b0, HYST_ON ? 1'b0 : 1'b1);
      run4("rel_2383", 2383, 2048, HYST_ON ? 2'b11 : 2'b00, 2'b00,
           2'b00, 2'b00, 1'b0, HYST_ON ? 1'b1 : 1'b0);

      // Inclusive entry boundaries, then one code inside the dead zone
      run4("bound_in", 2448, 1648, 2'b00, 2'b00, 2'b11, 2'b10, 1'b0, 1'b1);
      run4("bound_edge", 2447, 1649, 2'b11, 2'b10,
           HYST_ON ? 2'b11 : 2'b00, HYST_ON ? 2'b10 : 2'b00, 1'b0, HYST_ON ? 1'b0 : 1'b1);
      run4("bound_back", 2048, 2048, HYST_ON ? 2'b11 : 2'b00, HYST_ON ? 2'b10 : 2'b00,
           2'b00, 2'b00, 1'b0, HYST_ON ? 1'b1 : 1'b0);

      // Interrupted confirmation, then left
      for (int i = 0; i < 3; i++)
         sample("interrupt", 3000, 2048, 2'b00, 2'b00, 1'b0, 1'b0);
      sample("interrupt_neutral", 2048, 2048, 2'b00, 2'b00, 1'b0, 1'b0);
      run4("left", 1000, 2048, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1);

      // Diagonal committed on one edge
      run4("to_neutral", 2048, 2048, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
      run4("diag", 1000, 3500, 2'b00, 2'b00, 2'b10, 2'b11, 1'b0, 1'b1);
      run4("diag_back", 2048, 2048, 2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
      run4("right2", 3000, 2048, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1);

      // Stop glitch of 10 cycles is rejected
      stop_btn_n = 1'b0;
      repeat (10) idle("glitch_low", 2'b11, 2'b00, 1'b0, 1'b0);
      stop_btn_n = 1'b1;
      repeat (25) idle("glitch_after", 2'b11, 2'b00, 1'b0, 1'b0);

      // Held press accepted on the 19th edge, axes forced neutral
      stop_btn_n = 1'b0;
      repeat (18) idle("stop_wait", 2'b11, 2'b00, 1'b0, 1'b0);
      idle("stop_on", 2'b00, 2'b00, 1'b1, 1'b1);
      run4("stop_held", 3000, 3500, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      stop_btn_n = 1'b1;
      repeat (18) idle("stop_rel_wait", 2'b00, 2'b00, 1'b1, 1'b0);
      idle("stop_off", 2'b00, 2'b00, 1'b0, 1'b1);
      run4("after_stop", 3000, 2048, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1);

      // Asynchronous reset between clocks, then full re-confirmation
      #2 iRST_N = 1'b0;
      #1;
      push_exp("async_reset", 2'b00, 2'b00, 1'b0, 1'b0);
      check_out();
      @(negedge iCLK);
      iRST_N = 1'b1;
      run4("post_reset", 3000, 2048, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/direction_encoder.md
# direction_encoder

Converts joystick ADC samples and a raw stop push-button into the registered 2-bit direction codes (`data_x`, `data_y`) and the `data_stop` flag consumed by the seven-segment direction display. It sits between the ADC sampler and the display driver. Each axis is classified against a dead-zone with optional hysteresis and must be confirmed over several consecutive samples before it is committed. The stop button is synchronised and debounced.

## Interface
- `ADC_W`, 12, ADC sample width.
- `CENTER`, 2048, neutral ADC code.
- `DEAD`, 400, dead-zone half-width.
- `HYST`, 64, hysteresis margin. Legal range: `HYST` < `DEAD`, `CENTER` ± `DEAD` within 0..2^ADC_W−1.
- `CONFIRM`, 4, consecutive agreeing samples required to commit (1..15).
- `STOP_DB_CYCLES`, 50000, stable cycles needed to accept a stop-button change (≥2).
- `iCLK`  in  1  clock.
- `iRST_N`  in  1  reset, asynchronous, active-low.
- `adc_x`  in  ADC_W  X-axis sample, qualified by `adc_valid`.
- `adc_y`  in  ADC_W  Y-axis sample, qualified by `adc_valid`.
- `adc_valid`  in  1  one-cycle strobe; both samples are valid.
- `stop_btn_n`  in  1  raw asynchronous push-button, active-low (pressed = 0).
- `data_x`  out  2  00 neutral, 10 left, 11 right.
- `data_y`  out  2  00 neutral, 10 down, 11 up.
- `data_stop`  out  1  debounced stop, 1 = pressed.
- `dir_changed`  out  1  one-cycle pulse when {data_x, data_y, data_stop} changes.

## Operation
- Per-axis committed state: NEUTRAL, NEG, POS. Output code:
  - NEUTRAL → 00.
  - NEG → 10 (X = left, Y = down).
  - POS → 11 (X = right, Y = up).
  - Code 01 is never driven.
- Raw classification of each valid sample uses unsigned compares in ADC_W+1 bits:
  - POS if sample ≥ `CENTER`+`DEAD`.
  - NEG if sample ≤ `CENTER`−`DEAD`.
  - Otherwise NEUTRAL.
  - Boundaries are inclusive.
- Confirmation, per axis: candidate class plus a 4-bit counter.
  - Sample class == committed state → counter cleared.
  - Sample class == candidate → counter increments (saturating).
  - Any other class → candidate becomes the new class, counter = 1.
  - When counter reaches `CONFIRM`, the candidate is committed and the counter is cleared.
- The two axes are independent, so diagonals are legal (e.g. 10/11).
- `adc_valid` low: no classification activity.
- Stop path:
  - 2-flop synchroniser, then a debounce counter.
  - Any level change restarts the count.
  - After `STOP_DB_CYCLES` stable cycles, the debounced level is accepted.
- While `data_stop` = 1:
  - Both axes are forced to NEUTRAL, and candidates and counters are cleared.
  - `adc_valid` is ignored.
  - On release, classification restarts from NEUTRAL.
- `dir_changed` compares the next-state outputs with the current registered outputs.

## Timing
- Reset values: `data_x`=00, `data_y`=00, `data_stop`=0, `dir_changed`=0.
- Reset also clears the internal counters and sets the synchroniser flops to 1 (released).
- Reset asserted mid-operation clears all outputs immediately (asynchronously). Operation resumes on the first edge after deassertion.
- Commit latency: outputs update on the clock edge after the `CONFIRM`-th agreeing `adc_valid` cycle.
- `dir_changed` is high in the same cycle as the updated outputs.
- Stop latency: 2 sync cycles + `STOP_DB_CYCLES` + 1 register cycle from a stable input level.
- Stop acceptance and an `adc_valid` on the same cycle: stop wins, and the sample is dropped.
- Back-to-back `adc_valid` every cycle is supported.

## Configuration
- `DIRENC_HYST_EN` defined: the release threshold of a committed direction is relaxed by `HYST`.
  - Committed POS holds while sample ≥ `CENTER`+`DEAD`−`HYST`.
  - Committed NEG holds while sample ≤ `CENTER`−`DEAD`+`HYST`.
  - Entry thresholds are unchanged.
- `DIRENC_HYST_EN` undefined: `HYST` is ignored, and entry and release thresholds are equal.

## Structure
- Shared package `direction_pkg`:
  - Axis-state enum (NEUTRAL/NEG/POS).
  - 2-bit code constants DIR_NONE=00, DIR_NEG=10, DIR_POS=11.
- Sub-module `axis_classifier` holds the threshold compare, the confirm FSM and the committed output. It is instantiated once per axis, with a `clear` input driven by `data_stop`.
- The stop synchroniser and debounce logic live in the top level.

## Test plan
All scenarios use defaults except `STOP_DB_CYCLES`=16; thresholds are 2448/1648.
- Four valid samples X=3000, Y=2048 → `data_x`=11, `data_y`=00 one cycle after the 4th sample; `dir_changed` pulses once.
- Three samples X=3000 then one X=2048 → `data_x` stays 00 and no `dir_changed`. Four further X=1000 → `data_x`=10.
- Commit right, then four samples X=2400:
  - With `DIRENC_HYST_EN`: `data_x` stays 11.
  - Without: `data_x`=00.
  - Both builds: X=2383 ×4 → 00.
- Four samples X=1000, Y=3500 → `data_x`=10, `data_y`=11 on the same cycle.
- Stop button:
  - `stop_btn_n` glitches low for 10 cycles → `data_stop` stays 0.
  - Held low → `data_stop`=1 and axes forced to 00 after 19 cycles; `adc_valid` samples are ignored while held.
- With `data_x`=11 committed, assert `iRST_N` low between clocks → all outputs 0 immediately. After release, four X=3000 samples are needed again before `data_x`=11.
